// File: rtl/decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue
// Brief    : Decode stage with integer/predicate register files, busy-bit
//            scoreboard and a one-entry issue register toward execution.
// Revision : 1.0
// ============================================================================
module decode_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  EX,
    output logic [31:0] Rx,
    output logic [31:0] Ry,
    output logic        Px,
    output logic        Py,
    output logic [31:0] imm_s,
    output logic [31:0] pc_n,
    output logic [4:0]  rd,
    output logic        rd_pred,
    output logic        rd_en,
    output logic        illegal,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_we_p,
    input  logic [2:0]  wb_addr_p,
    input  logic        wb_data_p,
    input  logic        flush
);

    logic [5:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [6:0]  w_ex;
    logic        w_rd_en, w_rd_pred, w_illegal;
    logic        w_use_i1, w_use_i2, w_use_p1, w_use_p2;
    logic        w_hazard, w_accept;
    logic [31:0] w_wb_clr_i, w_busy_i_eff, w_busy_i_nxt;
    logic [7:0]  w_wb_clr_p, w_busy_p_eff, w_busy_p_nxt;
    logic [31:0] w_src1, w_src2;
    logic        w_psrc1, w_psrc2;

    logic [31:0] r_gpr [32];
    logic [7:0]  r_pr;
    logic [31:0] r_busy_i;
    logic [7:0]  r_busy_p;
    logic        r_out_valid;
    logic [6:0]  r_ex;
    logic [31:0] r_rx, r_ry, r_imm, r_pcn;
    logic        r_px, r_py;
    logic [4:0]  r_rd;
    logic        r_rd_pred, r_rd_en, r_illegal;

    assign w_op  = instr[31:26];
    assign w_rd  = instr[25:21];
    assign w_rs1 = instr[20:16];
    assign w_rs2 = instr[15:11];

    always_comb begin
        w_ex      = 7'd0;
        w_rd_en   = 1'b0;
        w_rd_pred = 1'b0;
        w_illegal = 1'b0;
        w_use_i1  = 1'b0;
        w_use_i2  = 1'b0;
        w_use_p1  = 1'b0;
        w_use_p2  = 1'b0;
        if (w_op >= 6'h01 && w_op <= 6'h0E) begin
            w_ex     = {(w_op == 6'h0E), 1'b0, w_op[3:0], 1'b1};
            w_rd_en  = 1'b1;
            w_use_i1 = 1'b1;
            w_use_i2 = 1'b1;
        end else if (w_op >= 6'h11 && w_op <= 6'h1D) begin
            w_ex     = {1'b0, 1'b1, w_op[3:0], 1'b1};
            w_rd_en  = 1'b1;
            w_use_i1 = (w_op != 6'h1D);
        end else if (w_op >= 6'h21 && w_op <= 6'h27) begin
            w_ex      = {3'b000, w_op[2:0], 1'b0};
            w_rd_en   = 1'b1;
            w_rd_pred = 1'b1;
            if (w_op <= 6'h24) begin
                w_use_p1 = 1'b1;
                w_use_p2 = (w_op != 6'h24);
            end else begin
                w_use_i1 = 1'b1;
            end
        end else if (w_op != 6'h00) begin
            w_illegal = 1'b1;
        end
    end

    // A writeback landing this cycle already frees its register for the reader
    assign w_wb_clr_i   = wb_we_i ? (32'd1 << wb_addr_i) : 32'd0;
    assign w_wb_clr_p   = wb_we_p ? (8'd1 << wb_addr_p) : 8'd0;
    assign w_busy_i_eff = r_busy_i & ~w_wb_clr_i;
    assign w_busy_p_eff = r_busy_p & ~w_wb_clr_p;

    assign w_hazard = (w_use_i1 & w_busy_i_eff[w_rs1])
                    | (w_use_i2 & w_busy_i_eff[w_rs2])
                    | (w_use_p1 & w_busy_p_eff[w_rs1[2:0]])
                    | (w_use_p2 & w_busy_p_eff[w_rs2[2:0]])
                    | (w_rd_en & (w_rd_pred ? w_busy_p_eff[w_rd[2:0]] : w_busy_i_eff[w_rd]));

    assign in_ready = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept = in_valid & in_ready;

    assign w_src1  = (wb_we_i && wb_addr_i == w_rs1 && w_rs1 != 5'd0) ? wb_data_i : r_gpr[w_rs1];
    assign w_src2  = (wb_we_i && wb_addr_i == w_rs2 && w_rs2 != 5'd0) ? wb_data_i : r_gpr[w_rs2];
    assign w_psrc1 = (wb_we_p && wb_addr_p == w_rs1[2:0]) ? wb_data_p : r_pr[w_rs1[2:0]];
    assign w_psrc2 = (wb_we_p && wb_addr_p == w_rs2[2:0]) ? wb_data_p : r_pr[w_rs2[2:0]];

    // Set is applied last so a new claim beats a same-cycle release
    always_comb begin
        w_busy_i_nxt = w_busy_i_eff;
        w_busy_p_nxt = w_busy_p_eff;
        if (flush && r_out_valid && r_rd_en) begin
            if (r_rd_pred) w_busy_p_nxt[r_rd[2:0]] = 1'b0;
            else           w_busy_i_nxt[r_rd]      = 1'b0;
        end
        if (w_accept && w_rd_en) begin
            if (w_rd_pred)             w_busy_p_nxt[w_rd[2:0]] = 1'b1;
            else if (w_rd != 5'd0)     w_busy_i_nxt[w_rd]      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) r_gpr[i] <= 32'd0;
            r_pr <= 8'd0;
        end else begin
            if (wb_we_i && wb_addr_i != 5'd0) r_gpr[wb_addr_i] <= wb_data_i;
            if (wb_we_p)                      r_pr[wb_addr_p]  <= wb_data_p;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_i    <= 32'd0;
            r_busy_p    <= 8'd0;
            r_out_valid <= 1'b0;
            r_ex        <= 7'd0;
            r_rx        <= 32'd0;
            r_ry        <= 32'd0;
            r_px        <= 1'b0;
            r_py        <= 1'b0;
            r_imm       <= 32'd0;
            r_pcn       <= 32'd0;
            r_rd        <= 5'd0;
            r_rd_pred   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_busy_i <= w_busy_i_nxt;
            r_busy_p <= w_busy_p_nxt;
            if (flush)           r_out_valid <= 1'b0;
            else if (w_accept)   r_out_valid <= 1'b1;
            else if (out_ready)  r_out_valid <= 1'b0;
            if (w_accept) begin
                r_ex      <= w_ex;
                r_rx      <= w_src2;
                r_ry      <= w_src1;
                r_px      <= w_psrc2;
                r_py      <= w_psrc1;
                r_imm     <= {{16{instr[15]}}, instr[15:0]};
                r_pcn     <= pc_in;
                r_rd      <= w_rd_pred ? {2'b00, w_rd[2:0]} : w_rd;
                r_rd_pred <= w_rd_pred;
                r_rd_en   <= w_rd_en;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign EX        = r_ex;
    assign Rx        = r_rx;
    assign Ry        = r_ry;
    assign Px        = r_px;
    assign Py        = r_py;
    assign imm_s     = r_imm;
    assign pc_n      = r_pcn;
    assign rd        = r_rd;
    assign rd_pred   = r_rd_pred;
    assign rd_en     = r_rd_en;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue
// Brief    : Directed and randomized bench for decode_issue against a
//            behavioural model of the decode/scoreboard rules.
// Revision : 1.0
// ============================================================================
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [31:0] instr = 32'd0, pc_in = 32'd0;
    logic        wb_we_i = 1'b0, wb_we_p = 1'b0, wb_data_p = 1'b0;
    logic [4:0]  wb_addr_i = 5'd0;
    logic [2:0]  wb_addr_p = 3'd0;
    logic [31:0] wb_data_i = 32'd0;

    logic        in_ready, out_valid, Px, Py, rd_pred, rd_en, illegal;
    logic [6:0]  EX;
    logic [31:0] Rx, Ry, imm_s, pc_n;
    logic [4:0]  rd;

    int checks = 0;
    int errors = 0;

    decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
        .EX(EX), .Rx(Rx), .Ry(Ry), .Px(Px), .Py(Py), .imm_s(imm_s), .pc_n(pc_n),
        .rd(rd), .rd_pred(rd_pred), .rd_en(rd_en), .illegal(illegal),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .wb_we_p(wb_we_p), .wb_addr_p(wb_addr_p), .wb_data_p(wb_data_p),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [6:0] ex;
        logic rd_en, rd_pred, ill, ui1, ui2, up1, up2;
    } dec_t;

    logic [31:0] m_gpr [32];
    bit          m_pr  [8];
    bit          m_bi  [32];
    bit          m_bp  [8];
    bit          m_valid;
    logic [6:0]  m_ex;
    logic [31:0] m_rx, m_ry, m_imm, m_pcn;
    bit          m_px, m_py, m_rd_en, m_rd_pred, m_ill;
    logic [4:0]  m_rd;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        int o;
        d = '0;
        o = int'(op);
        if (o >= 1 && o <= 14) begin
            d.ex = 7'(1 + 2 * (o % 16) + (o == 14 ? 64 : 0));
            d.rd_en = 1; d.ui1 = 1; d.ui2 = 1;
        end else if (o >= 17 && o <= 29) begin
            d.ex = 7'(1 + 32 + 2 * (o % 16));
            d.rd_en = 1; d.ui1 = (o != 29);
        end else if (o >= 33 && o <= 39) begin
            d.ex = 7'(2 * (o % 8));
            d.rd_en = 1; d.rd_pred = 1;
            if (o <= 36) begin d.up1 = 1; d.up2 = (o != 36); end
            else d.ui1 = 1;
        end else if (o != 0) begin
            d.ill = 1;
        end
        return d;
    endfunction

    function automatic bit ibusy(input int r);
        return m_bi[r] && !(wb_we_i && int'(wb_addr_i) == r);
    endfunction

    function automatic bit pbusy(input int r);
        return m_bp[r] && !(wb_we_p && int'(wb_addr_p) == r);
    endfunction

    function automatic bit m_ready();
        dec_t d;
        bit   hz;
        int   f_rd, s1, s2;
        d = decode(instr[31:26]);
        f_rd = int'(instr[25:21]); s1 = int'(instr[20:16]); s2 = int'(instr[15:11]);
        hz = 0;
        if (d.ui1 && ibusy(s1)) hz = 1;
        if (d.ui2 && ibusy(s2)) hz = 1;
        if (d.up1 && pbusy(s1 % 8)) hz = 1;
        if (d.up2 && pbusy(s2 % 8)) hz = 1;
        if (d.rd_en && (d.rd_pred ? pbusy(f_rd % 8) : ibusy(f_rd))) hz = 1;
        return (!m_valid || out_ready) && !hz && !flush;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin m_gpr[i] = 32'd0; m_bi[i] = 0; end
        for (int i = 0; i < 8; i++)  begin m_pr[i] = 0; m_bp[i] = 0; end
        m_valid = 0; m_ex = 7'd0; m_rx = 0; m_ry = 0; m_imm = 0; m_pcn = 0;
        m_px = 0; m_py = 0; m_rd_en = 0; m_rd_pred = 0; m_ill = 0; m_rd = 5'd0;
    endtask

    task automatic m_step();
        dec_t d;
        bit   acc;
        int   f_rd, s1, s2;
        acc  = in_valid && m_ready();
        d    = decode(instr[31:26]);
        f_rd = int'(instr[25:21]); s1 = int'(instr[20:16]); s2 = int'(instr[15:11]);
        if (wb_we_i) m_bi[wb_addr_i] = 0;
        if (wb_we_p) m_bp[wb_addr_p] = 0;
        if (flush && m_valid && m_rd_en) begin
            if (m_rd_pred) m_bp[m_rd % 8] = 0;
            else           m_bi[m_rd] = 0;
        end
        // writes land first, so a same-cycle reader naturally sees the new value
        if (wb_we_i && wb_addr_i != 5'd0) m_gpr[wb_addr_i] = wb_data_i;
        if (wb_we_p) m_pr[wb_addr_p] = wb_data_p;
        if (acc) begin
            m_ex = d.ex; m_rd_en = d.rd_en; m_rd_pred = d.rd_pred; m_ill = d.ill;
            m_ry = m_gpr[s1]; m_rx = m_gpr[s2];
            m_py = m_pr[s1 % 8]; m_px = m_pr[s2 % 8];
            m_imm = 32'($signed(instr[15:0]));
            m_pcn = pc_in;
            m_rd  = 5'(d.rd_pred ? f_rd % 8 : f_rd);
            if (d.rd_en) begin
                if (d.rd_pred)      m_bp[f_rd % 8] = 1;
                else if (f_rd != 0) m_bi[f_rd] = 1;
            end
        end
        if (flush)          m_valid = 0;
        else if (acc)       m_valid = 1;
        else if (out_ready) m_valid = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    // Compare process: outputs sampled mid-low-phase, after inputs settle
    initial begin
        forever begin
            @(negedge clk);
            #3;
            chk("in_ready", in_ready, m_ready());
            chk("out_valid", out_valid, m_valid);
            chk("EX", EX, m_ex);
            chk("Rx", Rx, m_rx);
            chk("Ry", Ry, m_ry);
            chk("Px", Px, m_px);
            chk("Py", Py, m_py);
            chk("imm_s", imm_s, m_imm);
            chk("pc_n", pc_n, m_pcn);
            chk("rd", rd, m_rd);
            chk("rd_en", rd_en, m_rd_en);
            chk("rd_pred", rd_pred, m_rd_pred);
            chk("illegal", illegal, m_ill);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] f_rd,
                                       input logic [4:0] s1, input logic [15:0] low);
        return {op, f_rd, s1, low};
    endfunction

    task automatic nxt();
        @(negedge clk);
        #1;
        in_valid = 0; flush = 0; wb_we_i = 0; wb_we_p = 0;
    endtask

    logic [5:0] r_ops [0:6];

    initial begin
        m_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst EX", EX, 0);
        chk("rst Ry", Ry, 0);
        chk("rst rd_en", rd_en, 0);

        // load r3/r4, then add r5 = r3 + r4
        nxt(); rst = 0; wb_we_i = 1; wb_addr_i = 3; wb_data_i = 32'h10;
        #2; chk("ready after reset", in_ready, 1);
        nxt(); wb_we_i = 1; wb_addr_i = 4; wb_data_i = 32'h5;
        nxt(); in_valid = 1; out_ready = 1; instr = mk(6'h01, 5, 3, {5'd4, 11'd0});
        #2; chk("add ready", in_ready, 1);
        nxt(); in_valid = 1; instr = mk(6'h01, 5, 5, 16'd0);
        #2;
        chk("add valid", out_valid, 1);
        chk("add EX", EX, 7'b0000011);
        chk("add Ry", Ry, 32'h10);
        chk("add Rx", Rx, 32'h5);
        chk("raw stall", in_ready, 0);
        nxt(); in_valid = 1; instr = mk(6'h01, 5, 5, 16'd0);
        wb_we_i = 1; wb_addr_i = 5; wb_data_i = 32'h77;
        #2; chk("wb unblocks", in_ready, 1); chk("drained", out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            nxt(); out_ready = 0; in_valid = 1; instr = 32'd0;
            #2;
            chk("stall valid", out_valid, 1);
            chk("bypass Ry", Ry, 32'h77);
            chk("stall ready", in_ready, 0);
        end
        nxt(); flush = 1;
        #2; chk("flush ready", in_ready, 0);
        nxt(); in_valid = 1; out_ready = 1; instr = mk(6'h11, 7, 5, 16'hFFFF);
        #2; chk("flushed valid", out_valid, 0); chk("r5 freed", in_ready, 1);
        nxt(); in_valid = 1; instr = mk(6'h0E, 8, 0, 16'd0); pc_in = 32'h12345678;
        #2; chk("addi imm", imm_s, 32'hFFFFFFFF); chk("addi EX", EX, 7'b0100011);
        chk("addi Ry", Ry, 32'h77);
        nxt(); in_valid = 1; instr = mk(6'h3F, 9, 0, 16'd0); pc_in = 32'd0;
        #2; chk("0E EX", EX, 7'b1011101); chk("0E pc_n", pc_n, 32'h12345678);
        nxt(); out_ready = 0; in_valid = 1; instr = 32'd0;
        #2; chk("illegal", illegal, 1); chk("ill EX", EX, 0); chk("ill rd_en", rd_en, 0);
        nxt(); in_valid = 1;
        #2; chk("ill stall", in_ready, 0);
        nxt(); rst = 1;
        #2; chk("midrst valid", out_valid, 0); chk("midrst ill", illegal, 0);
        chk("midrst pc_n", pc_n, 0); chk("midrst imm", imm_s, 0);
        nxt(); rst = 0; instr = mk(6'h01, 10, 7, {5'd8, 11'd0});
        #2; chk("busy cleared by rst", in_ready, 1);
        nxt(); wb_we_p = 1; wb_addr_p = 2; wb_data_p = 1;
        nxt(); in_valid = 1; out_ready = 1; instr = mk(6'h21, 1, 2, {5'd3, 11'd0});
        nxt();
        #2; chk("pred Py", Py, 1); chk("pred Px", Px, 0);
        chk("pred EX", EX, 7'b0000010); chk("pred rd_pred", rd_pred, 1);

        r_ops[0] = 6'h00; r_ops[1] = 6'h0F; r_ops[2] = 6'h10;
        r_ops[3] = 6'h1E; r_ops[4] = 6'h20; r_ops[5] = 6'h28; r_ops[6] = 6'h3F;
        for (int c = 0; c < 2500; c++) begin
            logic [5:0] op;
            int cat;
            nxt();
            rst = ($urandom_range(0, 299) == 0);
            cat = $urandom_range(0, 9);
            case (cat)
                0, 1, 2: op = 6'($urandom_range(1, 14));
                3, 4:    op = 6'($urandom_range(17, 29));
                5, 6:    op = 6'($urandom_range(33, 36));
                7:       op = 6'($urandom_range(37, 39));
                8:       op = r_ops[$urandom_range(0, 6)];
                default: op = 6'($urandom);
            endcase
            instr = mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
            if ($urandom_range(0, 9) == 0) instr[25:11] = 15'($urandom);
            pc_in     = $urandom;
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            wb_we_i   = ($urandom_range(0, 1) == 1);
            wb_addr_i = 5'($urandom_range(0, 7));
            wb_data_i = $urandom;
            wb_we_p   = ($urandom_range(0, 4) < 2);
            wb_addr_p = 3'($urandom_range(0, 7));
            wb_data_p = 1'($urandom);
        end
        nxt();
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
